// File: rtl/trng_entropy_arbiter_if.sv
// Source and block handshake bundle for the TRNG entropy arbiter.
// The arbiter connects through the slave modport; the source/consumer side uses master.
interface trng_entropy_arbiter_if;
    logic [2:0]   src_enabled;
    logic [2:0]   src_syn;
    logic [95:0]  src_data;
    logic [2:0]   src_ack;
    logic         block_syn;
    logic [511:0] block_data;
    logic         block_ack;

    modport slave (
        input  src_enabled,
        input  src_syn,
        input  src_data,
        input  block_ack,
        output src_ack,
        output block_syn,
        output block_data
    );

    modport master (
        output src_enabled,
        output src_syn,
        output src_data,
        output block_ack,
        input  src_ack,
        input  block_syn,
        input  block_data
    );
endinterface

// File: rtl/trng_entropy_arbiter.sv
// Round-robin collector of 32-bit entropy words from 3 sources into a 512-bit block.
// States: IDLE idle | COLLECT await eligible word | ACK one-cycle source ack | DONE block held for consumer
module trng_entropy_arbiter (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    trng_entropy_arbiter_if.slave bus,
    output logic                  busy,
    output logic                  no_source
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ACK     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     word_ctr_q, word_ctr_d;
    logic [1:0]     rr_ptr_q, rr_ptr_d;
    logic [511:0]   block_q, block_d;
    logic [2:0]     src_ack_q, src_ack_d;

    logic [2:0]     eligible;
    logic [2:0]     cand;
    logic           grant_vld;
    logic [1:0]     grant_idx;
    logic [31:0]    grant_word;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            word_ctr_q <= 5'd0;
            rr_ptr_q   <= 2'd0;
            block_q    <= '0;
            src_ack_q  <= 3'b000;
        end else begin
            state_q    <= state_d;
            word_ctr_q <= word_ctr_d;
            rr_ptr_q   <= rr_ptr_d;
            block_q    <= block_d;
            src_ack_q  <= src_ack_d;
        end
    end

    // First eligible source scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
    always_comb begin
        eligible  = bus.src_syn & bus.src_enabled;
        cand      = 3'd0;
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!grant_vld && eligible[cand[1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[1:0];
            end
        end
    end

    always_comb begin
        case (grant_idx)
            2'd0:    grant_word = bus.src_data[31:0];
            2'd1:    grant_word = bus.src_data[63:32];
            default: grant_word = bus.src_data[95:64];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        word_ctr_d = word_ctr_q;
        rr_ptr_d   = rr_ptr_q;
        block_d    = block_q;
        src_ack_d  = 3'b000;
        case (state_q)
            IDLE: begin
                word_ctr_d = 5'd0;
                if (enable) state_d = COLLECT;
            end
            COLLECT: begin
                if (!enable) begin
                    state_d    = IDLE;
                    word_ctr_d = 5'd0;
                end else if (grant_vld) begin
                    block_d    = {block_q[479:0], grant_word};
                    word_ctr_d = word_ctr_q + 5'd1;
                    rr_ptr_d   = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
                    src_ack_d  = 3'b001 << grant_idx;
                    state_d    = ACK;
                end
            end
            ACK: begin
                if (!enable) begin
                    state_d    = IDLE;
                    word_ctr_d = 5'd0;
                end else if (word_ctr_q == 5'd16) begin
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                end
            end
            DONE: begin
                // Completed block survives enable=0 until the consumer takes it.
                if (bus.block_ack) begin
                    word_ctr_d = 5'd0;
                    state_d    = enable ? COLLECT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.src_ack    = src_ack_q;
    assign bus.block_syn  = (state_q == DONE);
    assign bus.block_data = block_q;
    assign busy           = (state_q != IDLE);
    assign no_source      = enable & ~|bus.src_enabled;

endmodule

// File: tb/tb_trng_entropy_arbiter.sv
// Directed bench for trng_entropy_arbiter: single source, round-robin, stall,
// abort, backpressure and reset-in-ACK scenarios with hand-computed expectations.
module tb_trng_entropy_arbiter;

    logic clk;
    logic reset_n;
    logic enable;
    logic busy;
    logic no_source;

    int vectors;
    int miscompares;

    trng_entropy_arbiter_if bus ();

    trng_entropy_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .bus       (bus),
        .busy      (busy),
        .no_source (no_source)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] ramp(input logic [31:0] base, input bit step);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            r[511-32*k -: 32] = step ? base + 32'(k) : base;
        return r;
    endfunction

    // Feeds source 0 only; returns on block_syn, after stop_after acks, or on timeout.
    task automatic feed_src0(input logic [31:0] base, input bit step, input int stop_after,
                             input int stall_at, input int stall_cycles,
                             output int n_ack, output int syn_cyc, output int bad);
        int last_c;
        n_ack   = 0;
        syn_cyc = 0;
        bad     = 0;
        last_c  = 0;
        bus.src_data[31:0] = base;
        for (int c = 1; c <= 120 && syn_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.src_ack !== 3'b000) begin
                if (bus.src_ack !== 3'b001) bad++;
                if (stall_cycles == 0 && c - last_c != 2) bad++;
                last_c = c;
                n_ack++;
                if (step) bus.src_data[31:0] = base + 32'(n_ack);
                if (n_ack == stop_after) return;
                if (n_ack == stall_at && stall_cycles > 0) begin
                    bus.src_syn = 3'b000;
                    repeat (stall_cycles) begin
                        @(negedge clk);
                        if (bus.src_ack !== 3'b000 || busy !== 1'b1 || bus.block_syn !== 1'b0) bad++;
                    end
                    bus.src_syn = 3'b001;
                end
            end
            if (bus.block_syn === 1'b1) syn_cyc = c;
        end
    endtask

    task automatic release_block(input logic en_after);
        enable        = en_after;
        bus.block_ack = 1'b1;
        @(negedge clk);
        bus.block_ack = 1'b0;
    endtask

    initial begin
        int n_ack, syn_cyc, bad;
        int order[$];
        logic [511:0] exp_blk;

        vectors       = 0;
        miscompares   = 0;
        reset_n       = 1'b0;
        enable        = 1'b0;
        bus.src_enabled = 3'b000;
        bus.src_syn   = 3'b000;
        bus.src_data  = '0;
        bus.block_ack = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset_busy", 512'(busy), 512'(1'b0));
        chk("reset_block_syn", 512'(bus.block_syn), 512'(1'b0));
        chk("reset_src_ack", 512'(bus.src_ack), 512'(3'b000));
        chk("reset_block_data", bus.block_data, '0);
        chk("reset_no_source_dis", 512'(no_source), 512'(1'b0));
        reset_n = 1'b1;

        // Single source, constant word
        bus.src_enabled = 3'b001;
        bus.src_syn     = 3'b001;
        enable          = 1'b1;
        feed_src0(32'h0102_0304, 1'b0, 0, 0, 0, n_ack, syn_cyc, bad);
        chk("single_acks", 512'(n_ack), 512'(16));
        chk("single_syn_cycle", 512'(syn_cyc), 512'(33));
        chk("single_ack_pattern", 512'(bad), 512'(0));
        chk("single_block", bus.block_data, ramp(32'h0102_0304, 1'b0));
        release_block(1'b0);
        chk("single_release_syn", 512'(bus.block_syn), 512'(1'b0));
        chk("single_release_busy", 512'(busy), 512'(1'b0));

        // Reset clears rr_ptr so round-robin starts at source 0
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("reset2_block_data", bus.block_data, '0);

        // Round-robin over all three sources
        bus.src_enabled = 3'b111;
        bus.src_syn     = 3'b111;
        bus.src_data    = {32'hC000_0000, 32'hB000_0000, 32'hA000_0000};
        enable          = 1'b1;
        syn_cyc         = 0;
        bad             = 0;
        for (int c = 1; c <= 80 && syn_cyc == 0; c++) begin
            @(negedge clk);
            case (bus.src_ack)
                3'b000: ;
                3'b001: order.push_back(0);
                3'b010: order.push_back(1);
                3'b100: order.push_back(2);
                default: order.push_back(3);
            endcase
            if (bus.block_syn === 1'b1) syn_cyc = c;
        end
        for (int i = 0; i < order.size(); i++)
            if (order[i] != i % 3) bad++;
        chk("rr_ack_count", 512'(order.size()), 512'(16));
        chk("rr_order", 512'(bad), 512'(0));
        chk("rr_syn_cycle", 512'(syn_cyc), 512'(33));
        chk("rr_word0", 512'(bus.block_data[511:480]), 512'(32'hA000_0000));
        chk("rr_word1", 512'(bus.block_data[479:448]), 512'(32'hB000_0000));
        chk("rr_word15", 512'(bus.block_data[31:0]), 512'(32'hA000_0000));
        for (int k = 0; k < 16; k++)
            exp_blk[511-32*k -: 32] = (k % 3 == 0) ? 32'hA000_0000 :
                                      (k % 3 == 1) ? 32'hB000_0000 : 32'hC000_0000;
        chk("rr_block", bus.block_data, exp_blk);
        release_block(1'b0);
        chk("rr_release_busy", 512'(busy), 512'(1'b0));

        // Stall after word 5; rr_ptr is 1 here, source 0 must still be found
        bus.src_enabled = 3'b001;
        bus.src_syn     = 3'b001;
        enable          = 1'b1;
        feed_src0(32'h3000_0000, 1'b1, 0, 5, 10, n_ack, syn_cyc, bad);
        chk("stall_acks", 512'(n_ack), 512'(16));
        chk("stall_hold", 512'(bad), 512'(0));
        chk("stall_completed", 512'(syn_cyc != 0), 512'(1'b1));
        chk("stall_block", bus.block_data, ramp(32'h3000_0000, 1'b1));
        release_block(1'b0);

        // Abort after word 7, then full block with no stale words
        enable = 1'b1;
        feed_src0(32'h4000_0000, 1'b1, 7, 0, 0, n_ack, syn_cyc, bad);
        chk("abort_partial_acks", 512'(n_ack), 512'(7));
        enable = 1'b0;
        @(negedge clk);
        chk("abort_busy", 512'(busy), 512'(1'b0));
        chk("abort_src_ack", 512'(bus.src_ack), 512'(3'b000));
        @(negedge clk);
        enable = 1'b1;
        feed_src0(32'h5000_0000, 1'b1, 0, 0, 0, n_ack, syn_cyc, bad);
        chk("reenable_acks", 512'(n_ack), 512'(16));
        chk("reenable_syn_cycle", 512'(syn_cyc), 512'(33));
        chk("reenable_pattern", 512'(bad), 512'(0));
        chk("reenable_block", bus.block_data, ramp(32'h5000_0000, 1'b1));

        // Backpressure in DONE with enable low and noisy sources
        enable          = 1'b0;
        bus.block_ack   = 1'b0;
        bus.src_enabled = 3'b111;
        bus.src_syn     = 3'b111;
        bus.src_data    = {3{32'hDEAD_BEEF}};
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.block_syn !== 1'b1 || bus.src_ack !== 3'b000 ||
                bus.block_data !== ramp(32'h5000_0000, 1'b1)) bad++;
        end
        chk("backpressure_stable", 512'(bad), 512'(0));
        release_block(1'b0);
        chk("backpressure_release_syn", 512'(bus.block_syn), 512'(1'b0));
        chk("backpressure_release_busy", 512'(busy), 512'(1'b0));

        // Reset while in ACK
        bus.src_enabled = 3'b001;
        bus.src_syn     = 3'b001;
        bus.src_data    = {3{32'h7777_0000}};
        enable          = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 6 && n_ack == 0; c++) begin
            @(negedge clk);
            if (bus.src_ack === 3'b001) n_ack = 1;
        end
        chk("rst_ack_reached", 512'(n_ack), 512'(1));
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_ack_src_ack", 512'(bus.src_ack), 512'(3'b000));
        chk("rst_ack_busy", 512'(busy), 512'(1'b0));
        chk("rst_ack_block_syn", 512'(bus.block_syn), 512'(1'b0));
        chk("rst_ack_block_data", bus.block_data, '0);
        bus.src_enabled = 3'b000;
        #1;
        chk("no_source_high", 512'(no_source), 512'(1'b1));
        enable = 1'b0;
        #1;
        chk("no_source_disabled", 512'(no_source), 512'(1'b0));
        reset_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trng_entropy_arbiter.md
TRNG_ENTROPY_ARBITER -- requirements
Module: trng_entropy_arbiter

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  collection enable.
- src_enabled  in  3  per-source enabled flag; bit i = source i.
- src_syn  in  3  per-source word-valid.
- src_data  in  96  source i word at [32*i+31 : 32*i].
- src_ack  out  3  per-source one-cycle word acknowledge.
- block_syn  out  1  512-bit block valid.
- block_data  out  512  assembled block; first word collected in [511:480].
- block_ack  in  1  consumer accepts block.
- busy  out  1  high in any state other than IDLE.
- no_source  out  1  high when enable=1 and src_enabled=0.
REQ-002 The block SHALL have no parameters; the source count is fixed at 3 and the block size at 16 words.

Function
REQ-003 The block SHALL implement the FSM states IDLE, COLLECT, ACK and DONE.
REQ-004 IDLE: the FSM SHALL go to COLLECT when enable=1; the word counter is cleared.
REQ-005 COLLECT:
- Eligible source: src_syn[i] & src_enabled[i].
- Source i SHALL be granted by round-robin starting at rr_ptr, then rr_ptr+1, rr_ptr+2, all mod 3.
REQ-006 On a grant to source i the block SHALL, on the same edge:
- shift block_reg left by 32 bits and load src_data word i into [31:0];
- increment word_ctr (5 bits, 0..16);
- set rr_ptr to (i+1) mod 3;
- register src_ack[i]=1;
- go to ACK.
REQ-007 With no eligible source, COLLECT SHALL hold state, word_ctr and rr_ptr.
REQ-008 ACK:
- src_ack SHALL be high for exactly this one cycle, on the granted bit only.
- No grant SHALL occur in ACK; each word costs exactly 2 cycles minimum.
- Next state SHALL be DONE if word_ctr=16, else COLLECT.
REQ-009 At most one src_ack bit SHALL be high in any cycle; src_ack SHALL be 0 outside ACK.
REQ-010 DONE:
- block_syn SHALL be 1 and block_data SHALL hold stable.
- On block_ack=1: word_ctr SHALL be cleared, block_syn SHALL drop next cycle, and the FSM SHALL go to COLLECT if enable=1, else to IDLE.
REQ-011 block_data SHALL be driven continuously from block_reg; it is only meaningful while block_syn=1.
REQ-012 enable=0 while in COLLECT or ACK SHALL, on the next edge:
- force IDLE and clear word_ctr, discarding the partial block;
- still deassert any pending src_ack after its single cycle.
REQ-013 enable=0 in DONE SHALL NOT discard the block; the FSM waits for block_ack, then goes to IDLE.
REQ-014 block_ack outside DONE SHALL be ignored.
REQ-015 A source whose src_enabled drops while in ACK SHALL still receive its ack cycle; it is skipped from the next COLLECT.
REQ-016 busy SHALL be registered-state decode: 0 in IDLE, 1 otherwise.
REQ-017 no_source SHALL be combinational: enable & ~|src_enabled.

Reset
REQ-018 On reset_n=0 at a clock edge the block SHALL set: state=IDLE, word_ctr=0, rr_ptr=0, block_reg=0, src_ack=0, block_syn=0, busy=0.
REQ-019 Reset SHALL take priority over all other inputs, including mid-COLLECT, ACK and DONE; any partial or completed block is lost.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Single source: src_enabled=001, src_syn=001, src0 data=0x01020304, enable=1 -> 16 acks to src0 only, one every 2 cycles; block_syn at cycle 33 after enable; block_data = 16 copies of 0x01020304.
- Round-robin: all 3 sources syn'd with 0xA0000000/0xB0000000/0xC0000000 -> capture order 0,1,2,0,1,... ; block_data[511:480]=0xA0000000, [479:448]=0xB0000000, [31:0]=0xA0000000 (word 15 = src0).
- Stall: src_syn=000 for 10 cycles after word 5 -> word_ctr holds 5, no ack, busy=1; completes normally once syn returns.
- Abort: enable dropped after word 7 -> IDLE next edge, busy=0; re-enable -> full 16-word block, no stale words.
- Backpressure: block_ack held 0 for 20 cycles in DONE with enable=0 -> block_syn and block_data stable; ack -> IDLE, block_syn=0 next cycle.
- Reset mid-ACK: reset_n=0 in ACK -> src_ack=0, state=IDLE and all outputs 0 on that edge; no_source=1 when enable=1 and src_enabled=000.
